// File: rtl/floppy_pkg.sv
// floppy_pkg: shared types and constants for the floppy-to-SD block port arbiter
package floppy_pkg;
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;
  localparam int NUM_DRIVES = 2;
  localparam int LBA_W = 32;
  localparam logic [23:0] TIMEOUT_DEFAULT = 24'd10_000_000;
endpackage

// File: rtl/floppy_sd_arbiter.sv
// floppy_sd_arbiter: round-robin sharing of one SD block port between two floppy drives
module floppy_sd_arbiter
  import floppy_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LBA_W-1:0] req_lba0,
  input  logic [LBA_W-1:0] req_lba1,
  input  logic             req_rd0,
  input  logic             req_wr0,
  input  logic             req_rd1,
  input  logic             req_wr1,
  output logic             req_ack0,
  output logic             req_ack1,
  input  logic [7:0]       req_din0,
  input  logic [7:0]       req_din1,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  input  logic             sd_ack,
  output logic [7:0]       sd_buff_din,
  output logic             grant,
  output logic             busy,
  output logic             timeout_err
);
  state_t state, state_n;
  logic last_grant, pend0, pend1, pick, start, abort, done;
  logic [23:0] wait_cnt;
  always_comb begin
    pend0 = req_rd0 | req_wr0;
    pend1 = req_rd1 | req_wr1;
    pick = (pend0 && pend1) ? ~last_grant : pend1;
    start = state == IDLE && !sd_ack && (pend0 || pend1);
    abort = state == REQ && !sd_ack && wait_cnt == TIMEOUT - 24'd1;
    done = state == XFER && !sd_ack;
    state_n = start ? REQ : (state == REQ && sd_ack) ? XFER : (abort || done) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sd_rd <= 1'b0;
      sd_wr <= 1'b0;
      sd_lba <= '0;
      grant <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      timeout_err <= abort;
      if (start) begin
        grant <= pick;
        sd_lba <= pick ? req_lba1 : req_lba0;
        sd_wr <= pick ? req_wr1 : req_wr0;
        sd_rd <= pick ? !req_wr1 : !req_wr0;
        wait_cnt <= '0;
      end else if (state == REQ) begin
        if (sd_ack || abort) begin
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
        end else
          wait_cnt <= wait_cnt + 24'd1;
      end
      if (abort || done) last_grant <= grant;
    end
  end
  assign busy = state != IDLE;
  assign req_ack0 = busy && !grant && sd_ack;
  assign req_ack1 = busy && grant && sd_ack;
  assign sd_buff_din = grant ? req_din1 : req_din0;
endmodule

// File: tb/tb_floppy_sd_arbiter.sv
// tb_floppy_sd_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_floppy_sd_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] req_lba0 = '0, req_lba1 = '0, sd_lba;
  logic req_rd0 = 0, req_wr0 = 0, req_rd1 = 0, req_wr1 = 0, req_ack0, req_ack1;
  logic [7:0] req_din0 = '0, req_din1 = '0, sd_buff_din;
  logic sd_rd, sd_wr, sd_ack = 1'b0, grant, busy, timeout_err;
  int pass_n = 0, total_n = 0;

  floppy_sd_arbiter #(.TIMEOUT(24'(TO))) dut (
    .clk(clk), .reset(reset),
    .req_lba0(req_lba0), .req_lba1(req_lba1),
    .req_rd0(req_rd0), .req_wr0(req_wr0), .req_rd1(req_rd1), .req_wr1(req_wr1),
    .req_ack0(req_ack0), .req_ack1(req_ack1),
    .req_din0(req_din0), .req_din1(req_din1),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_din(sd_buff_din), .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", pass_n, total_n);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int d, input logic rd, input logic wr, input logic [31:0] lba);
    if (d == 0) begin req_rd0 = rd; req_wr0 = wr; req_lba0 = lba; end
    else begin req_rd1 = rd; req_wr1 = wr; req_lba1 = lba; end
  endtask

  // upstream host: ack after delay cycles, hold for len edges; requesters drop on seeing their ack
  task automatic serve(input int delay, input int len);
    repeat (delay) step();
    sd_ack = 1'b1;
    #1;
    if (req_ack0) begin req_rd0 = 0; req_wr0 = 0; end
    if (req_ack1) begin req_rd1 = 0; req_wr1 = 0; end
    repeat (len) step();
    sd_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; sd_ack = 1'b1;
    step(); step(); #1;
    total_n++; if (sd_rd !== 1'b0) $display("FAIL rst_sd_rd: got %b want 0", sd_rd); else pass_n++;
    total_n++; if (sd_wr !== 1'b0) $display("FAIL rst_sd_wr: got %b want 0", sd_wr); else pass_n++;
    total_n++; if (sd_lba !== 32'h0) $display("FAIL rst_sd_lba: got %h want 0", sd_lba); else pass_n++;
    total_n++; if (grant !== 1'b0) $display("FAIL rst_grant: got %b want 0", grant); else pass_n++;
    total_n++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_n++;
    total_n++; if ({req_ack0, req_ack1} !== 2'b00) $display("FAIL rst_acks: got %b%b want 00", req_ack0, req_ack1); else pass_n++;
    reset = 1'b0; sd_ack = 1'b0;
    step();
  endtask

  task automatic test_read();
    int bad = 0;
    set_req(0, 1, 0, 32'h1A);
    step();
    total_n++; if ({busy, grant, sd_rd, sd_wr} !== 4'b1010) $display("FAIL read_grant: got busy/grant/rd/wr %b%b%b%b want 1010", busy, grant, sd_rd, sd_wr); else pass_n++;
    total_n++; if (sd_lba !== 32'h1A) $display("FAIL read_lba: got %h want 1a", sd_lba); else pass_n++;
    repeat (5) step();
    total_n++; if (sd_rd !== 1'b1) $display("FAIL read_rd_hold: got %b want 1", sd_rd); else pass_n++;
    sd_ack = 1'b1;
    #1;
    total_n++; if ({req_ack0, req_ack1} !== 2'b10) $display("FAIL read_ack_comb: got %b%b want 10", req_ack0, req_ack1); else pass_n++;
    total_n++; if (sd_rd !== 1'b1) $display("FAIL read_rd_same_cycle: got %b want 1", sd_rd); else pass_n++;
    req_rd0 = 0;
    step();
    total_n++; if (sd_rd !== 1'b0) $display("FAIL read_rd_drop: got %b want 0", sd_rd); else pass_n++;
    for (int i = 0; i < 511; i++) begin
      if (req_ack0 !== 1'b1 || req_ack1 !== 1'b0) bad++;
      step();
    end
    total_n++; if (bad != 0) $display("FAIL read_ack_block: got %0d bad cycles want 0", bad); else pass_n++;
    sd_ack = 1'b0;
    #1;
    total_n++; if ({req_ack0, busy} !== 2'b01) $display("FAIL read_ack_fall: got ack0/busy %b%b want 01", req_ack0, busy); else pass_n++;
    step();
    total_n++; if (busy !== 1'b0) $display("FAIL read_done: got busy %b want 0", busy); else pass_n++;
  endtask

  task automatic test_both();
    reset = 1'b1; step(); reset = 1'b0;
    set_req(0, 1, 0, 32'h11);
    set_req(1, 1, 0, 32'h27);
    step();
    total_n++; if (grant !== 1'b0 || sd_lba !== 32'h11) $display("FAIL both_first: got grant %b lba %h want 0 11", grant, sd_lba); else pass_n++;
    serve(2, 8);
    total_n++; if (busy !== 1'b0) $display("FAIL both_idle_gap: got busy %b want 0", busy); else pass_n++;
    step();
    total_n++; if ({busy, grant, sd_rd} !== 3'b111 || sd_lba !== 32'h27) $display("FAIL both_second: got busy/grant/rd %b%b%b lba %h want 111 27", busy, grant, sd_rd, sd_lba); else pass_n++;
    serve(1, 4);
  endtask

  task automatic test_write();
    req_din0 = 8'h3C; req_din1 = 8'hA5;
    set_req(1, 0, 1, 32'h0D);
    step();
    total_n++; if ({grant, sd_wr, sd_rd} !== 3'b110 || sd_lba !== 32'h0D) $display("FAIL write_grant: got grant/wr/rd %b%b%b lba %h want 110 0d", grant, sd_wr, sd_rd, sd_lba); else pass_n++;
    set_req(0, 1, 0, 32'h55);
    step();
    sd_ack = 1'b1;
    #1;
    total_n++; if ({req_ack0, req_ack1} !== 2'b01) $display("FAIL write_acks: got %b%b want 01", req_ack0, req_ack1); else pass_n++;
    req_wr1 = 0;
    step();
    total_n++; if (sd_buff_din !== 8'hA5 || sd_wr !== 1'b0) $display("FAIL write_xfer: got din %h wr %b want a5 0", sd_buff_din, sd_wr); else pass_n++;
    total_n++; if (sd_lba !== 32'h0D || grant !== 1'b1 || req_ack0 !== 1'b0) $display("FAIL write_stable: got lba %h grant %b ack0 %b want 0d 1 0", sd_lba, grant, req_ack0); else pass_n++;
    repeat (3) step();
    sd_ack = 1'b0;
    step();
    step();
    total_n++; if (grant !== 1'b0 || sd_lba !== 32'h55 || sd_rd !== 1'b1) $display("FAIL write_next: got grant %b lba %h rd %b want 0 55 1", grant, sd_lba, sd_rd); else pass_n++;
    serve(0, 3);
  endtask

  task automatic test_timeout();
    int n = 0;
    set_req(0, 1, 0, 32'h40);
    step();
    while (sd_rd === 1'b1 && n < 40) begin n++; step(); end
    total_n++; if (n != TO) $display("FAIL timeout_len: got %0d rd cycles want %0d", n, TO); else pass_n++;
    total_n++; if (timeout_err !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_pulse: got err %b busy %b want 1 0", timeout_err, busy); else pass_n++;
    step();
    total_n++; if ({timeout_err, busy, grant, sd_rd} !== 4'b0101) $display("FAIL timeout_regrant: got err/busy/grant/rd %b%b%b%b want 0101", timeout_err, busy, grant, sd_rd); else pass_n++;
    serve(0, 3);
  endtask

  task automatic test_reset_mid_xfer();
    int bad = 0;
    set_req(1, 1, 0, 32'h66);
    step();
    sd_ack = 1'b1;
    #1;
    req_rd1 = 0;
    step();
    set_req(0, 1, 0, 32'h77);
    reset = 1'b1;
    step();
    #1;
    total_n++; if ({busy, sd_rd, grant, req_ack0, req_ack1} !== 5'b0 || sd_lba !== 32'h0) $display("FAIL midrst_outputs: got busy/rd/grant/ack0/ack1 %b%b%b%b%b lba %h want 00000 0", busy, sd_rd, grant, req_ack0, req_ack1, sd_lba); else pass_n++;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (busy !== 1'b0 || req_ack0 !== 1'b0) bad++;
    end
    total_n++; if (bad != 0) $display("FAIL midrst_stale_ack: got %0d granted cycles want 0", bad); else pass_n++;
    sd_ack = 1'b0;
    step();
    total_n++; if ({busy, grant} !== 2'b10 || sd_lba !== 32'h77) $display("FAIL midrst_grant: got busy/grant %b%b lba %h want 10 77", busy, grant, sd_lba); else pass_n++;
    serve(0, 2);
  endtask

  task automatic test_random();
    logic pend [2];
    logic pwr [2];
    logic [31:0] plba [2];
    logic last = 1'b1;
    logic g;
    int d, n;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    reset = 1'b1; step(); reset = 1'b0;
    pend[0] = 0; pend[1] = 0;
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          d = int'($urandom_range(2, 0));
          pend[i] = 1; pwr[i] = d != 0; plba[i] = $urandom;
          set_req(i, d != 1, d != 0, plba[i]);
        end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1; pwr[0] = 0; plba[0] = $urandom;
        set_req(0, 1, 0, plba[0]);
      end
      g = (pend[0] && pend[1]) ? !last : pend[1];
      step();
      total_n++; if (busy !== 1'b1 || grant !== g) $display("FAIL rand_grant[%0d]: got busy %b grant %b want 1 %b", k, busy, grant, g); else pass_n++;
      total_n++; if (sd_lba !== plba[g] || sd_wr !== pwr[g] || sd_rd !== !pwr[g]) $display("FAIL rand_cmd[%0d]: got lba %h wr %b rd %b want %h %b %b", k, sd_lba, sd_wr, sd_rd, plba[g], pwr[g], !pwr[g]); else pass_n++;
      if ($urandom_range(4, 0) == 0) begin
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; step(); end
        total_n++; if (n != TO || timeout_err !== 1'b1) $display("FAIL rand_timeout[%0d]: got %0d cycles err %b want %0d 1", k, n, timeout_err, TO); else pass_n++;
      end else begin
        repeat ($urandom_range(10, 0)) step();
        if (!pend[!g] && $urandom_range(1, 0) == 1) begin
          pend[!g] = 1; pwr[!g] = 0; plba[!g] = $urandom;
          set_req(int'(!g), 1, 0, plba[!g]);
        end
        sd_ack = 1'b1;
        #1;
        total_n++; if ((g ? req_ack1 : req_ack0) !== 1'b1 || (g ? req_ack0 : req_ack1) !== 1'b0) $display("FAIL rand_ack[%0d]: got %b%b for grant %b", k, req_ack0, req_ack1, g); else pass_n++;
        pend[g] = 0;
        set_req(int'(g), 0, 0, $urandom);
        req_din0 = 8'($urandom); req_din1 = 8'($urandom);
        step();
        total_n++; if (sd_buff_din !== (g ? req_din1 : req_din0) || {sd_rd, sd_wr} !== 2'b00 || sd_lba !== plba[g]) $display("FAIL rand_xfer[%0d]: got din %h rd/wr %b%b lba %h want %h 00 %h", k, sd_buff_din, sd_rd, sd_wr, sd_lba, g ? req_din1 : req_din0, plba[g]); else pass_n++;
        repeat ($urandom_range(5, 0)) step();
        sd_ack = 1'b0;
        step();
        total_n++; if (busy !== 1'b0) $display("FAIL rand_done[%0d]: got busy %b want 0", k, busy); else pass_n++;
      end
      last = g;
    end
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_both();
    test_write();
    test_timeout();
    test_reset_mid_xfer();
    test_random();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
